// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, flag bundle and FSM state encoding.
package alu_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int OP_WIDTH_DEF   = 4;
   localparam int TAG_WIDTH_DEF  = 4;

   typedef logic [DATA_WIDTH_DEF-1:0] alu_data_t;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_LUI = 4'd5,
      OP_LLI = 4'd6,
      OP_SLL = 4'd7,
      OP_SRL = 4'd8,
      OP_SLA = 4'd9,
      OP_SRA = 4'd10,
      OP_MUL = 4'd11
   } alu_op_t;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } alu_flags_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock.
// The start cycle already retires the first bit, so the product is ready W-1 edges later.
module alu_mul_iter #(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_start,
   input  logic [W-1:0]   i_a,
   input  logic [W-1:0]   i_b,
   output logic           o_busy,
   output logic           o_done,
   output logic [2*W-1:0] o_product
);

   localparam int CW = $clog2(W);

   logic [2*W-1:0] r_prod;
   logic [W-1:0]   r_a;
   logic [CW-1:0]  r_cnt;
   logic           r_busy;

   // Upper half accumulates the multiplicand; lower half shifts the multiplier out.
   function automatic logic [2*W-1:0] f_step(input logic [2*W-1:0] p, input logic [W-1:0] a);
      logic [W:0] s;
      s = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, a} : {(W+1){1'b0}});
      return {s, p[W-1:1]};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prod <= '0;
         r_a    <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_a    <= i_a;
         r_prod <= f_step({{W{1'b0}}, i_b}, i_a);
         r_cnt  <= CW'(W-1);
         r_busy <= 1'b1;
      end else if (r_busy) begin
         if (r_cnt == '0) begin
            r_busy <= 1'b0;
         end else begin
            r_prod <= f_step(r_prod, r_a);
            r_cnt  <= r_cnt - 1'b1;
         end
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_busy && (r_cnt == '0);
   assign o_product = r_prod;

endmodule

// File: rtl/alu_seq.sv
// Registered, valid/ready ALU with flags, tag passthrough and an iterative MUL.
//   state   | meaning
//   ST_IDLE | accepting requests; single-cycle ops resolve here
//   ST_MUL  | multiplier iterating, in_ready held low
module alu_seq
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int OP_WIDTH   = OP_WIDTH_DEF,
   parameter int TAG_WIDTH  = TAG_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   input  logic [OP_WIDTH-1:0]   in_op,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_r,
   output logic [TAG_WIDTH-1:0]  out_tag,
   output logic                  out_z,
   output logic                  out_n,
   output logic                  out_c,
   output logic                  out_v,
   output logic                  out_err
);

   localparam int W   = DATA_WIDTH;
   localparam int H   = W / 2;
   localparam int SHW = $clog2(W);

   alu_state_t            r_state;
   alu_state_t            w_state_nxt;
   logic                  w_ready;
   logic                  w_accept;
   logic                  w_mul_start;
   logic                  w_mul_busy;
   logic                  w_mul_done;
   logic [2*W-1:0]        w_mul_prod;
   logic [TAG_WIDTH-1:0]  r_mul_tag;

   logic [W-1:0]          w_res;
   logic                  w_c;
   logic                  w_v;
   logic                  w_err;
   logic                  w_is_mul;
   alu_flags_t            w_flags;
   alu_flags_t            w_mul_flags;

   logic [SHW-1:0]        w_sh;
   logic [W:0]            w_add;
   logic [W:0]            w_sub;
   logic [W:0]            w_shl;
   logic [W:0]            w_srl;
   logic [W:0]            w_sra;

   logic                  r_out_valid;
   logic [W-1:0]          r_out_r;
   logic [TAG_WIDTH-1:0]  r_out_tag;
   alu_flags_t            r_out_flags;
   logic                  r_out_err;

   // Shifts carry one guard bit so the last bit shifted out lands in it.
   assign w_sh  = in_b[SHW-1:0];
   assign w_add = {1'b0, in_a} + {1'b0, in_b};
   assign w_sub = {1'b0, in_a} + {1'b0, ~in_b} + (W+1)'(1);
   assign w_shl = {1'b0, in_a} << w_sh;
   assign w_srl = {in_a, 1'b0} >> w_sh;
   assign w_sra = $unsigned($signed({in_a, 1'b0}) >>> w_sh);

   always_comb begin
      w_res    = '0;
      w_c      = 1'b0;
      w_v      = 1'b0;
      w_err    = 1'b0;
      w_is_mul = 1'b0;
      case (in_op)
         OP_WIDTH'(OP_ADD): begin
            w_res = w_add[W-1:0];
            w_c   = w_add[W];
            w_v   = (in_a[W-1] == in_b[W-1]) && (w_add[W-1] != in_a[W-1]);
         end
         OP_WIDTH'(OP_SUB): begin
            w_res = w_sub[W-1:0];
            w_c   = w_sub[W];
            w_v   = (in_a[W-1] != in_b[W-1]) && (w_sub[W-1] != in_a[W-1]);
         end
         OP_WIDTH'(OP_AND): w_res = in_a & in_b;
         OP_WIDTH'(OP_OR):  w_res = in_a | in_b;
         OP_WIDTH'(OP_XOR): w_res = in_a ^ in_b;
         OP_WIDTH'(OP_LUI): w_res = {in_b[H-1:0], {H{1'b0}}};
         OP_WIDTH'(OP_LLI): w_res = {{H{1'b0}}, in_b[H-1:0]};
         OP_WIDTH'(OP_SLL), OP_WIDTH'(OP_SLA): begin
            w_res = w_shl[W-1:0];
            w_c   = w_shl[W];
         end
         OP_WIDTH'(OP_SRL): begin
            w_res = w_srl[W:1];
            w_c   = w_srl[0];
         end
         OP_WIDTH'(OP_SRA): begin
            w_res = w_sra[W:1];
            w_c   = w_sra[0];
         end
         OP_WIDTH'(OP_MUL): w_is_mul = 1'b1;
         default:           w_err    = 1'b1;
      endcase
      // Illegal ops report only err; z is suppressed along with the other flags.
      w_flags.z = !w_err && (w_res == '0);
      w_flags.n = w_res[W-1];
      w_flags.c = w_c;
      w_flags.v = w_v;
   end

   always_comb begin
      w_mul_flags.z = (w_mul_prod[W-1:0] == '0);
      w_mul_flags.n = w_mul_prod[W-1];
      w_mul_flags.c = |w_mul_prod[2*W-1:W];
      w_mul_flags.v = |w_mul_prod[2*W-1:W];
   end

   alu_mul_iter #(.W(W)) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_start   (w_mul_start),
      .i_a       (in_a),
      .i_b       (in_b),
      .o_busy    (w_mul_busy),
      .o_done    (w_mul_done),
      .o_product (w_mul_prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_mul_start) w_state_nxt = ST_MUL;
         ST_MUL:  if (w_mul_done)  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_ready     = rst_n && (r_state == ST_IDLE) && !w_mul_busy && (!r_out_valid || out_ready);
      w_accept    = in_valid && w_ready;
      w_mul_start = w_accept && w_is_mul;
   end

   assign in_ready = w_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_r     <= '0;
         r_out_tag   <= '0;
         r_out_flags <= '0;
         r_out_err   <= 1'b0;
         r_mul_tag   <= '0;
      end else if (w_accept) begin
         if (w_is_mul) begin
            r_out_valid <= 1'b0;
            r_mul_tag   <= in_tag;
         end else begin
            r_out_valid <= 1'b1;
            r_out_r     <= w_res;
            r_out_tag   <= in_tag;
            r_out_flags <= w_flags;
            r_out_err   <= w_err;
         end
      end else if ((r_state == ST_MUL) && w_mul_done) begin
         r_out_valid <= 1'b1;
         r_out_r     <= w_mul_prod[W-1:0];
         r_out_tag   <= r_mul_tag;
         r_out_flags <= w_mul_flags;
         r_out_err   <= 1'b0;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_r     = r_out_r;
   assign out_tag   = r_out_tag;
   assign out_z     = r_out_flags.z;
   assign out_n     = r_out_flags.n;
   assign out_c     = r_out_flags.c;
   assign out_v     = r_out_flags.v;
   assign out_err   = r_out_err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: scoreboard of expected results checked as they leave the block.
module tb_alu_seq;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [3:0]  in_op = '0;
   logic [3:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_r;
   logic [3:0]  out_tag;
   logic        out_z, out_n, out_c, out_v, out_err;

   typedef struct {
      logic [31:0] r;
      logic [3:0]  tag;
      logic [3:0]  zncv;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   alu_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_r     (out_r),
      .out_tag   (out_tag),
      .out_z     (out_z),
      .out_n     (out_n),
      .out_c     (out_c),
      .out_v     (out_v),
      .out_err   (out_err)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", name, got, exp);
      end
   endtask

   // A transfer seen at the falling edge completes at the following rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL unexpected_result: observed r=%h tag=%h expected no result", out_r, out_tag);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("r_tag%0d", e.tag), out_r, e.r);
            check($sformatf("tag_tag%0d", e.tag), {28'd0, out_tag}, {28'd0, e.tag});
            check($sformatf("zncv_tag%0d", e.tag), {28'd0, out_z, out_n, out_c, out_v}, {28'd0, e.zncv});
            check($sformatf("err_tag%0d", e.tag), {31'd0, out_err}, {31'd0, e.err});
         end
      end
   end

   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic [31:0] er, input logic [3:0] ezncv,
                       input logic eerr);
      exp_t e;
      logic acc;
      e.r = er; e.tag = tag; e.zncv = ezncv; e.err = eerr;
      sb.push_back(e);
      in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            acc = 1'b1;
         end
      end
      in_valid = 1'b0;
      check($sformatf("accept_tag%0d", tag), {31'd0, acc}, 32'd1);
   endtask

   // Called #1 after the accept edge; counts further edges until out_valid.
   task automatic latency(input string name, input int exp_cyc, input logic chk_ready);
      int cyc;
      int rdy;
      cyc = 0;
      rdy = 0;
      while (!out_valid && cyc < 100) begin
         if (in_ready) rdy++;
         @(posedge clk);
         #1;
         cyc++;
      end
      check(name, cyc, exp_cyc);
      if (chk_ready) check({name, "_in_ready_low"}, rdy, 0);
   endtask

   initial begin
      int vc;
      #2;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_in_ready", {31'd0, in_ready}, 32'd0);
      check("reset_out_r", out_r, 32'd0);
      check("reset_flags_err", {27'd0, out_z, out_n, out_c, out_v, out_err}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      send(OP_ADD, 32'd12345, 32'd54321, 4'd1, 32'd66666, 4'b0000, 1'b0);
      latency("lat_add", 0, 1'b0);
      send(OP_SUB, 32'd5, 32'd5, 4'd2, 32'd0, 4'b1010, 1'b0);
      send(OP_ADD, 32'h7FFF_FFFF, 32'd1, 4'd3, 32'h8000_0000, 4'b0101, 1'b0);
      send(OP_ADD, 32'hFFFF_FFFF, 32'd1, 4'd4, 32'd0, 4'b1010, 1'b0);
      send(OP_SUB, 32'h8000_0000, 32'd1, 4'd5, 32'h7FFF_FFFF, 4'b0011, 1'b0);
      send(OP_SUB, 32'd0, 32'd1, 4'd6, 32'hFFFF_FFFF, 4'b0100, 1'b0);
      send(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd7, 32'h00F0_00F0, 4'b0000, 1'b0);
      send(OP_OR, 32'hF000_0000, 32'h0000_000F, 4'd8, 32'hF000_000F, 4'b0100, 1'b0);
      send(OP_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 4'd9, 32'd0, 4'b1000, 1'b0);
      send(OP_LUI, 32'd0, 32'h1234_ABCD, 4'd10, 32'hABCD_0000, 4'b0100, 1'b0);
      send(OP_LLI, 32'hFFFF_FFFF, 32'h1234_ABCD, 4'd11, 32'h0000_ABCD, 4'b0000, 1'b0);
      send(OP_SLL, 32'd12345, 32'd2, 4'd12, 32'd49380, 4'b0000, 1'b0);
      send(OP_SLL, 32'h8000_0000, 32'd32, 4'd13, 32'h8000_0000, 4'b0100, 1'b0);
      send(OP_SLA, 32'hC000_0000, 32'd1, 4'd14, 32'h8000_0000, 4'b0110, 1'b0);
      send(OP_SRL, 32'h8000_0001, 32'd1, 4'd15, 32'h4000_0000, 4'b0010, 1'b0);
      send(OP_SRA, 32'hFFFF_CFC7, 32'd5, 4'd1, 32'hFFFF_FE7E, 4'b0100, 1'b0);
      send(OP_SRA, 32'h8000_0000, 32'd31, 4'd2, 32'hFFFF_FFFF, 4'b0100, 1'b0);

      send(OP_MUL, 32'd12345, 32'd54321, 4'd3, 32'd670592745, 4'b0000, 1'b0);
      latency("lat_mul", 32, 1'b1);
      send(OP_MUL, 32'hFFFF_FFFF, 32'd2, 4'd4, 32'hFFFF_FFFE, 4'b0111, 1'b0);
      latency("lat_mul_ovf", 32, 1'b1);
      send(OP_MUL, 32'd0, 32'd5, 4'd5, 32'd0, 4'b1000, 1'b0);
      latency("lat_mul_zero", 32, 1'b1);

      send(4'hF, 32'd1, 32'd2, 4'd6, 32'd0, 4'b0000, 1'b1);
      latency("lat_illegal", 0, 1'b0);

      @(posedge clk);
      #1 out_ready = 1'b0;
      send(OP_ADD, 32'd100, 32'd200, 4'd7, 32'd300, 4'b0000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("hold_valid_%0d", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("hold_r_%0d", i), out_r, 32'd300);
         check($sformatf("hold_tag_%0d", i), {28'd0, out_tag}, 32'd7);
         check($sformatf("hold_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      send(OP_ADD, 32'd1, 32'd2, 4'd8, 32'd3, 4'b0000, 1'b0);
      latency("lat_drain_accept", 0, 1'b0);
      check("drain_accept_tag", {28'd0, out_tag}, 32'd8);

      send(OP_MUL, 32'd7, 32'd9, 4'd9, 32'd63, 4'b0000, 1'b0);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      void'(sb.pop_back());
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_in_ready", {31'd0, in_ready}, 32'd0);
      check("abort_out_r", out_r, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      vc = 0;
      repeat (45) begin
         @(posedge clk);
         #1;
         if (out_valid) vc++;
      end
      check("no_result_after_abort", vc, 0);

      send(OP_ADD, 32'd10, 32'd20, 4'd10, 32'd30, 4'b0000, 1'b0);
      latency("lat_after_reset", 0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Next-generation ALU: a registered, handshaked, parametrised successor of the combinational alu.
- Adds full flags (z, n, c, v), an op tag passthrough, an illegal-op error flag and a multi-cycle iterative MUL.
- Sits between the decode/issue stage and writeback, using valid/ready on both sides.

Parameters:
- DATA_WIDTH, 32, operand/result width; even, >= 8.
- OP_WIDTH, 4, width of the op code.
- TAG_WIDTH, 4, width of the opaque tag returned with each result.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_a  in  DATA_WIDTH  operand a.
- in_b  in  DATA_WIDTH  operand b / shift amount.
- in_op  in  OP_WIDTH  operation (alu_op_t).
- in_tag  in  TAG_WIDTH  tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_r  out  DATA_WIDTH  result.
- out_tag  out  TAG_WIDTH  tag of the result.
- out_z, out_n, out_c, out_v  out  1 each  zero, negative (r[MSB]), carry, signed overflow.
- out_err  out  1  illegal op code.

Behaviour:
- Reset (rst_n=0, async): state IDLE, all out_* = 0, out_valid = 0, MUL counter = 0; in_ready = 0 while rst_n=0.
- Reset mid-MUL aborts the operation; no result is emitted.
- Accept: in_valid && in_ready at a rising edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Same-cycle drain and accept is allowed; out_valid stays 1 with the new data.
- Output hold: while out_valid && !out_ready, all out_* are stable.
- FSM: IDLE -> MUL on accept of MUL; MUL -> IDLE after DATA_WIDTH iterations, loading the output register. All other ops stay in IDLE.
- Latency:
  - Single-cycle ops: out_valid on the edge after accept (1 cycle).
  - MUL: shift-add, one bit per cycle; out_valid DATA_WIDTH cycles after the accept edge. in_ready = 0 throughout.
- Ops; W = DATA_WIDTH, H = W/2, sh = b[$clog2(W)-1:0]:
  - ADD: r = a+b, mod 2^W. c = carry-out. v = signed overflow.
  - SUB: r = a+~b+1. c = carry-out (1 = no borrow). v = signed overflow.
  - AND, OR, XOR: bitwise; c = v = 0.
  - LUI: r = {b[H-1:0], H'0}.
  - LLI: r = {H'0, b[H-1:0]}.
  - SLL, SLA: r = a << sh.
  - SRL: logical right shift.
  - SRA: arithmetic right shift.
  - Shift carry: c = last bit shifted out; c = 0 when sh = 0. v = 0 for all shifts.
  - MUL: unsigned, r = low W bits of a*b. c = v = (high W bits != 0).
  - Undefined codes: r = 0, err = 1, other flags 0, latency 1.
- Flags for all ops: z = (r==0), n = r[W-1].
- Tag travels unchanged with its request. Results are delivered in order; only one request is in flight.

Decomposition:
- alu_pkg holds:
  - DATA_WIDTH/OP_WIDTH defaults.
  - alu_data_t and alu_op_t enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, LUI=5, LLI=6, SLL=7, SRL=8, SLA=9, SRA=10, MUL=11.
  - alu_flags_t struct {z,n,c,v}.
- Sub-module alu_mul_iter: iterative shift-add multiplier.
  - Signals: start/busy/done, a, b, product[2W-1:0].
  - Holds the counter and accumulator; alu_seq owns the handshake FSM and output register.

Test Plan:
- ADD 12345+54321, out_ready=1 -> one cycle later r=66666, z=n=c=v=0, tag echoed.
- SUB 5-5 -> r=0, z=1, c=1, v=0. ADD 0x7FFFFFFF+1 -> r=0x80000000, n=1, v=1, c=0.
- MUL 12345*54321 -> in_ready=0 for 32 cycles; out_valid 32 cycles after accept; r=670592745, c=v=0. MUL 0xFFFFFFFF*2 -> r=0xFFFFFFFE, c=v=1.
- SRA a=-12345 (0xFFFFCFC7) by 5 -> r=0xFFFFFE7E (-386), n=1, c=0. SLL 12345 by 2 -> r=49380. LUI b=0x1234ABCD -> r=0xABCD0000.
- Backpressure: hold out_ready=0 for 5 cycles after ADD -> out_* stable, in_ready=0. Then out_ready=1 with a new in_valid -> drain and accept in the same cycle, next result 1 cycle later.
- Reset: rst_n=0 at cycle 10 of a MUL -> out_valid=0 immediately; no result after release. Op=4'hF -> r=0, err=1, latency 1.
